// File: rtl/animated_bitmap_pkg.sv
// Shared types and constants for the animated sprite renderer.
//   rgb332_t             : 8-bit RGB332 colour
//   anim_mode_t          : LOOP / PINGPONG frame sequencing
//   dir_t                : PINGPONG stepping direction
//   TRANSPARENT_ENCODING : colour value that is never drawn
package animated_bitmap_pkg;

  typedef logic [7:0] rgb332_t;

  typedef enum logic {LOOP = 1'b0, PINGPONG = 1'b1} anim_mode_t;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  localparam rgb332_t TRANSPARENT_ENCODING = 8'hFF;
  // Colour of the sprite's rightmost column in every frame.
  localparam rgb332_t EDGE_COLOUR = 8'h4C;

  localparam int unsigned FRAME_W = 4;   // frame index width (up to 16 frames)
  localparam int unsigned HOLD_W  = 8;   // hold counter width (FRAME_HOLD up to 255)
  localparam int unsigned COORD_W = 11;  // pixel offset width

endpackage

// File: rtl/animated_bitmap_rom.sv
// Combinational sprite store: returns the texel colour for (frame, row, col).
//   i_frame    : animation frame
//   i_row      : texel row
//   i_col      : texel column
//   o_colour_c : texel colour (combinational)
// Texel map: the rightmost column is EDGE_COLOUR, the main diagonal
// (row == col) is transparent, every other texel is a frame-dependent hue in
// the top 3 bits with (col ^ row) in the low 5 bits.
module animated_bitmap_rom
  import animated_bitmap_pkg::*;
#(
  parameter int unsigned X_BITS = 5,
  parameter int unsigned Y_BITS = 5
) (
  input  logic [FRAME_W-1:0] i_frame,
  input  logic [Y_BITS-1:0]  i_row,
  input  logic [X_BITS-1:0]  i_col,
  output rgb332_t            o_colour_c
);

  logic [2:0]         w_hue;
  logic [COORD_W-1:0] w_col_ext;
  logic [COORD_W-1:0] w_row_ext;

  // Fold frame bit 3 into the hue so frames 8..15 differ from 0..7.
  assign w_hue     = i_frame[2:0] ^ {2'b00, i_frame[3]};
  assign w_col_ext = COORD_W'(i_col);
  assign w_row_ext = COORD_W'(i_row);

  // Texel lookup
  always_comb begin
    o_colour_c = {w_hue, 5'(w_col_ext ^ w_row_ext)};
    if (i_col == '1) begin
      o_colour_c = EDGE_COLOUR;
    end else if (w_col_ext == w_row_ext) begin
      o_colour_c = TRANSPARENT_ENCODING;
    end
  end

endmodule

// File: rtl/animated_bitmap.sv
// Animated sprite renderer: registered pixel lookup plus frame sequencer.
//   clk, resetN     : clock, async active-low reset
//   startOfFrame    : one-cycle pulse per video frame
//   offsetX/offsetY : pixel position relative to the sprite's top-left corner
//   InsideRectangle : pixel lies inside the sprite rectangle
//   animEnable      : animation runs while high
//   animMode        : 0 = LOOP, 1 = PINGPONG
//   mirrorX         : horizontal flip (honoured only with ANIMATED_BITMAP_MIRROR_EN)
//   drawingRequest  : pixel is opaque (1 clk after the offsets)
//   RGBout          : pixel colour, 8'h00 when not drawing
//   frameIndex      : current animation frame
// Optional feature: define ANIMATED_BITMAP_MIRROR_EN to enable mirrorX.
module animated_bitmap
  import animated_bitmap_pkg::*;
#(
  parameter int unsigned OBJECT_NUMBER_OF_X_BITS = 5,
  parameter int unsigned OBJECT_NUMBER_OF_Y_BITS = 5,
  parameter int unsigned NUM_FRAMES              = 4,
  parameter int unsigned FRAME_HOLD              = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] offsetX,
  input  logic [COORD_W-1:0] offsetY,
  input  logic               InsideRectangle,
  input  logic               animEnable,
  input  logic               animMode,
  input  logic               mirrorX,
  output logic               drawingRequest,
  output rgb332_t            RGBout,
  output logic [FRAME_W-1:0] frameIndex
);

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  LAST_HOLD  = HOLD_W'(FRAME_HOLD - 1);

  logic [FRAME_W-1:0]                 r_frame;
  logic [HOLD_W-1:0]                  r_hold;
  dir_t                               r_dir;
  logic                               r_draw;
  rgb332_t                            r_rgb;

  logic                               w_in_range;
  logic [OBJECT_NUMBER_OF_X_BITS-1:0] w_col;
  logic [OBJECT_NUMBER_OF_Y_BITS-1:0] w_row;
  rgb332_t                            w_colour;
  logic                               w_opaque;

  // Range check on the full offsets, before truncation to texel indices.
  assign w_in_range = InsideRectangle
                    && ((offsetX >> OBJECT_NUMBER_OF_X_BITS) == '0)
                    && ((offsetY >> OBJECT_NUMBER_OF_Y_BITS) == '0);

  assign w_row = offsetY[OBJECT_NUMBER_OF_Y_BITS-1:0];

`ifdef ANIMATED_BITMAP_MIRROR_EN
  // Bitwise inversion maps column c to 2^X-1-c.
  assign w_col = mirrorX ? ~offsetX[OBJECT_NUMBER_OF_X_BITS-1:0]
                         :  offsetX[OBJECT_NUMBER_OF_X_BITS-1:0];
`else
  logic w_unused_mirror;
  assign w_col           = offsetX[OBJECT_NUMBER_OF_X_BITS-1:0];
  assign w_unused_mirror = mirrorX;
`endif

  animated_bitmap_rom #(
    .X_BITS (OBJECT_NUMBER_OF_X_BITS),
    .Y_BITS (OBJECT_NUMBER_OF_Y_BITS)
  ) u_rom (
    .i_frame    (r_frame),
    .i_row      (w_row),
    .i_col      (w_col),
    .o_colour_c (w_colour)
  );

  assign w_opaque = w_in_range && (w_colour != TRANSPARENT_ENCODING);

  // Pixel output register; the lookup sees the frame held before any
  // startOfFrame on the same edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_draw <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_draw <= w_opaque;
      r_rgb  <= w_opaque ? w_colour : rgb332_t'(8'h00);
    end
  end

  // Frame sequencer: hold counter plus UP/DOWN direction FSM.
  // In LOOP mode the direction is forced back to UP on each advance.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hold  <= '0;
      r_frame <= '0;
      r_dir   <= UP;
    end else if (startOfFrame && animEnable) begin
      if (r_hold == LAST_HOLD) begin
        r_hold <= '0;
        if (NUM_FRAMES == 1) begin
          r_frame <= '0;
          r_dir   <= UP;
        end else if (anim_mode_t'(animMode) == LOOP) begin
          r_dir   <= UP;
          r_frame <= (r_frame == LAST_FRAME) ? '0 : r_frame + FRAME_W'(1);
        end else if (r_dir == UP) begin
          if (r_frame == LAST_FRAME) begin
            r_dir   <= DOWN;
            r_frame <= r_frame - FRAME_W'(1);
          end else begin
            r_frame <= r_frame + FRAME_W'(1);
          end
        end else begin
          if (r_frame == '0) begin
            r_dir   <= UP;
            r_frame <= FRAME_W'(1);
          end else begin
            r_frame <= r_frame - FRAME_W'(1);
          end
        end
      end else begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end
  end

  assign drawingRequest = r_draw;
  assign RGBout         = r_rgb;
  assign frameIndex     = r_frame;

endmodule

// File: tb/tb_animated_bitmap.sv
// Self-checking bench for animated_bitmap: two instances share the stimulus,
// the default one (FRAME_HOLD=8) and one with FRAME_HOLD=1 for fast PINGPONG.
// Expected pixels and frames are queued per cycle and checked by a monitor.
module tb_animated_bitmap;

  localparam int NF     = 4;
  localparam int HOLD   = 8;
  localparam int HOLD_P = 1;
  localparam int SPR    = 32;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] offsetX, offsetY;
  logic        InsideRectangle, animEnable, animMode, mirrorX;
  logic        drawingRequest, dr_pp;
  logic [7:0]  RGBout, rgb_pp;
  logic [3:0]  frameIndex, fi_pp;

  always #5 clk = ~clk;

  animated_bitmap u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
    .animEnable(animEnable), .animMode(animMode), .mirrorX(mirrorX),
    .drawingRequest(drawingRequest), .RGBout(RGBout), .frameIndex(frameIndex)
  );

  animated_bitmap #(.FRAME_HOLD(HOLD_P)) u_dut_pp (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
    .animEnable(animEnable), .animMode(animMode), .mirrorX(mirrorX),
    .drawingRequest(dr_pp), .RGBout(rgb_pp), .frameIndex(fi_pp)
  );

  typedef struct {
    int       due;
    bit       dr;
    int       rgb;
    int       frame;
    int       frame_pp;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference state: position on the frame "tour". A PINGPONG tour for
  // N frames is 0,1,..,N-1,N-2,..,1 (length 2N-2); LOOP restarts the tour
  // at the current frame going up.
  int pos_main, cnt_main, pos_pp, cnt_pp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int frame_of(input int pos);
    return (pos < NF) ? pos : 2 * (NF - 1) - pos;
  endfunction

  function automatic int next_pos(input int pos, input bit mode);
    if (NF == 1) return 0;
    if (!mode) return (frame_of(pos) + 1) % NF;
    return (pos + 1) % (2 * (NF - 1));
  endfunction

  function automatic logic [7:0] texel(input int frame, input int row, input int col);
    logic [7:0] c;
    int hue;
    hue = (frame ^ (frame >> 3)) & 7;
    if (col == SPR - 1)  c = 8'h4C;
    else if (row == col) c = 8'hFF;
    else                 c = 8'((hue << 5) | ((col ^ row) & 31));
    return c;
  endfunction

  task automatic model_reset();
    pos_main = 0; cnt_main = 0; pos_pp = 0; cnt_pp = 0;
  endtask

  // One clock of stimulus; queues the response expected after this edge.
  task automatic step(input bit sof, input bit en, input bit mode, input bit mir,
                      input int x, input int y, input bit ins);
    exp_t e;
    int col;
    logic [7:0] c;
    startOfFrame = sof; animEnable = en; animMode = mode; mirrorX = mir;
    offsetX = 11'(x); offsetY = 11'(y); InsideRectangle = ins;
    col = x;
`ifdef ANIMATED_BITMAP_MIRROR_EN
    if (mir) col = SPR - 1 - x;
`endif
    c = texel(frame_of(pos_main), y, col);
    e.dr  = ins && (x < SPR) && (y < SPR) && (c != 8'hFF);
    e.rgb = e.dr ? int'(c) : 0;
    if (sof && en) begin
      cnt_main++;
      if (cnt_main == HOLD) begin cnt_main = 0; pos_main = next_pos(pos_main, mode); end
      cnt_pp++;
      if (cnt_pp == HOLD_P) begin cnt_pp = 0; pos_pp = next_pos(pos_pp, mode); end
    end
    e.frame    = frame_of(pos_main);
    e.frame_pp = frame_of(pos_pp);
    e.due      = cyc + 1;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic rstep(input bit sof, input bit en, input bit mode, input bit mir);
    int x, y;
    x = ($urandom_range(0, 4) == 0) ? int'($urandom_range(32, 2047)) : int'($urandom_range(0, 31));
    y = ($urandom_range(0, 4) == 0) ? int'($urandom_range(32, 2047)) : int'($urandom_range(0, 31));
    step(sof, en, mode, mir, x, y, $urandom_range(0, 7) != 0);
  endtask

  // A startOfFrame pulse followed by a quiet pixel cycle.
  task automatic pulse(input bit en, input bit mode);
    rstep(1'b1, en, mode, 1'b0);
    rstep(1'b0, en, mode, 1'b0);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    q.delete();
    model_reset();
    startOfFrame = 0; animEnable = 0; animMode = 0; mirrorX = 0;
    offsetX = '0; offsetY = '0; InsideRectangle = 0;
    @(posedge clk); #1;
    resetN = 1'b1;
  endtask

  // Monitor: compares every due response against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("drawingRequest", int'(drawingRequest), int'(e.dr));
        chk("RGBout", int'(RGBout), e.rgb);
        chk("frameIndex", int'(frameIndex), e.frame);
        chk("frameIndex_hold1", int'(fi_pp), e.frame_pp);
      end
    end
  end

  initial begin
    int loop_exp[5] = '{1, 2, 3, 0, 1};
    int pp_exp[8]   = '{1, 2, 3, 2, 1, 0, 1, 2};
    bit en, mode, mir, sof, prev;
    int exp_mir;

    resetN = 1'b0;
    startOfFrame = 0; animEnable = 0; animMode = 0; mirrorX = 0;
    offsetX = '0; offsetY = '0; InsideRectangle = 0;
    model_reset();
    #12;
    chk("reset_dr", int'(drawingRequest), 0);
    chk("reset_rgb", int'(RGBout), 0);
    chk("reset_frame", int'(frameIndex), 0);
    @(posedge clk); #1;
    resetN = 1'b1;

    // Disabled animation never advances.
    for (int i = 0; i < 40; i++) pulse(1'b0, 1'b0);
    chk("disabled_frame", int'(frameIndex), 0);
    chk("disabled_frame_hold1", int'(fi_pp), 0);

    // LOOP: advance after every 8th pulse.
    for (int i = 1; i <= 40; i++) begin
      pulse(1'b1, 1'b0);
      if (i % 8 == 0) chk("loop_frame", int'(frameIndex), loop_exp[i/8-1]);
      if (i % 8 == 7) chk("loop_hold", int'(frameIndex), (i < 8) ? 0 : loop_exp[i/8-1]);
    end

    // PINGPONG with FRAME_HOLD=1 from a fresh reset.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pulse(1'b1, 1'b1);
      chk("pingpong_frame", int'(fi_pp), pp_exp[i]);
    end

    // Pixel boundary, transparency and mirror cases.
    step(1'b0, 1'b1, 1'b1, 1'b0, 31, 0, 1'b1);
    chk("px31_dr", int'(drawingRequest), 1);
    chk("px31_rgb", int'(RGBout), 8'h4C);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32, 0, 1'b1);
    chk("px32_dr", int'(drawingRequest), 0);
    chk("px32_rgb", int'(RGBout), 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 7, 7, 1'b1);
    chk("transparent_dr", int'(drawingRequest), 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 0, 5, 1'b1);
`ifdef ANIMATED_BITMAP_MIRROR_EN
    exp_mir = int'(texel(frame_of(pos_main), 5, 31));
`else
    exp_mir = int'(texel(frame_of(pos_main), 5, 0));
`endif
    chk("mirror_rgb", int'(RGBout), exp_mir);

    // Reset mid-hold at frame 2 restarts with a full hold period.
    do_reset();
    for (int i = 0; i < 19; i++) pulse(1'b1, 1'b0);
    chk("pre_reset_frame", int'(frameIndex), 2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 31, 3, 1'b1);
    chk("pre_reset_dr", int'(drawingRequest), 1);
    resetN = 1'b0;
    #1;
    chk("async_reset_dr", int'(drawingRequest), 0);
    chk("async_reset_rgb", int'(RGBout), 0);
    chk("async_reset_frame", int'(frameIndex), 0);
    q.delete();
    model_reset();
    startOfFrame = 0;
    @(posedge clk); #1;
    resetN = 1'b1;
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0);
    chk("post_reset_hold", int'(frameIndex), 0);
    pulse(1'b1, 1'b0);
    chk("post_reset_advance", int'(frameIndex), 1);

    // Randomized run: enable, mode and mirror vary; mode flips mid-animation.
    en = 1; mode = 0; mir = 0; prev = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        en  = ($urandom_range(0, 3) != 0);
        mir = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 99) < 3) mode = ~mode;
      sof  = !prev && ($urandom_range(0, 2) == 0);
      prev = sof;
      rstep(sof, en, mode, mir);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/animated_bitmap.md
ANIMATED_BITMAP -- requirements
Module: animated_bitmap

Interface
REQ-001 The block SHALL have parameter OBJECT_NUMBER_OF_X_BITS, default 5, meaning log2 of sprite width in pixels.
REQ-002 The block SHALL have parameter OBJECT_NUMBER_OF_Y_BITS, default 5, meaning log2 of sprite height in pixels.
REQ-003 The block SHALL have parameter NUM_FRAMES, default 4, meaning the number of animation frames (legal range 1..16).
REQ-004 The block SHALL have parameter FRAME_HOLD, default 8, meaning the number of startOfFrame pulses each frame is held (legal range 1..255).
REQ-005 The block SHALL have these ports, clock and reset first:
- clk  in  1  system clock; one clock only.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- offsetX  in  11  pixel column relative to the sprite's top-left corner.
- offsetY  in  11  pixel row relative to the sprite's top-left corner.
- InsideRectangle  in  1  current pixel lies within the sprite rectangle.
- animEnable  in  1  animation runs while high.
- animMode  in  1  0 = LOOP, 1 = PINGPONG.
- mirrorX  in  1  draw the sprite horizontally flipped.
- drawingRequest  out  1  pixel is opaque and must be drawn.
- RGBout  out  8  RGB332 pixel colour.
- frameIndex  out  4  current animation frame.

Function
REQ-006 Pixel outputs SHALL be registered, with exactly 1 clk of latency from offsetX/offsetY/InsideRectangle to drawingRequest/RGBout.
REQ-007 The block SHALL assert drawingRequest only when all three hold: InsideRectangle=1, offsetX < 2^OBJECT_NUMBER_OF_X_BITS and offsetY < 2^OBJECT_NUMBER_OF_Y_BITS, and the looked-up colour is not TRANSPARENT_ENCODING (8'hFF).
REQ-008 RGBout SHALL equal the looked-up colour when drawingRequest=1, and 8'h00 otherwise.
REQ-009 Column index SHALL be offsetX truncated to OBJECT_NUMBER_OF_X_BITS bits, and row index SHALL be offsetY truncated to OBJECT_NUMBER_OF_Y_BITS bits; truncation SHALL be applied only after the range check in REQ-007.
REQ-010 A hold counter SHALL increment on each startOfFrame while animEnable=1; on reaching FRAME_HOLD-1 it SHALL wrap to 0 and the frame SHALL advance.
REQ-011 In LOOP mode, the frame SHALL advance 0,1,..,NUM_FRAMES-1,0.
REQ-012 In PINGPONG mode, a two-state FSM (UP, DOWN) SHALL step the frame as follows:
- UP increments; at NUM_FRAMES-1 it switches to DOWN and decrements on the next advance.
- DOWN decrements; at 0 it switches to UP.
- For NUM_FRAMES=2 the frames SHALL alternate 0,1,0,1.
REQ-013 If NUM_FRAMES=1, frameIndex SHALL stay 0 and the FSM SHALL stay in UP.
REQ-014 While animEnable=0, the hold counter, the frame and the FSM state SHALL freeze; resuming SHALL continue from the frozen values.
REQ-015 If animMode changes while the FSM is in DOWN, the block SHALL set the FSM to UP at the next advance; the frame SHALL not jump.
REQ-016 frameIndex SHALL change only in the cycle after a startOfFrame, so no frame tears mid-screen.
REQ-017 startOfFrame coinciding with a pixel lookup SHALL use the old frame for that pixel.

Reset
REQ-018 While resetN=0, asynchronously: drawingRequest=0, RGBout=8'h00, frameIndex=0, hold counter=0, FSM=UP.
REQ-019 A reset asserted mid-animation SHALL restart the animation at frame 0 with a full FRAME_HOLD period.

Configuration
REQ-020 When ANIMATED_BITMAP_MIRROR_EN is defined, mirrorX=1 SHALL map column c to (2^OBJECT_NUMBER_OF_X_BITS-1-c), with REQ-006 latency unchanged.
REQ-021 When ANIMATED_BITMAP_MIRROR_EN is undefined, the mirrorX port SHALL remain present but be ignored.

Structure
REQ-022 Package animated_bitmap_pkg SHALL hold:
- typedef rgb332_t (8 bits);
- enum anim_mode_t {LOOP, PINGPONG};
- enum dir_t {UP, DOWN};
- constant TRANSPARENT_ENCODING = 8'hFF.
REQ-023 Sub-module animated_bitmap_rom SHALL be combinational: (frame, row, col) in, rgb332_t colour out, holding the per-frame sprite constants.

Verification
REQ-024 Reset release, animEnable=0, 40 startOfFrame pulses -> frameIndex stays 0.
REQ-025 LOOP mode, FRAME_HOLD=8, NUM_FRAMES=4, 40 pulses -> frameIndex advances after pulses 8, 16, 24, 32, 40 through 1, 2, 3, 0, 1.
REQ-026 PINGPONG mode, FRAME_HOLD=1, NUM_FRAMES=4, 8 pulses -> frameIndex sequence 1, 2, 3, 2, 1, 0, 1, 2.
REQ-027 Pixel at offset (31,0) with InsideRectangle=1 and opaque colour 8'h4C -> drawingRequest=1 and RGBout=8'h4C one cycle later; offset (32,0) -> drawingRequest=0 and RGBout=8'h00.
REQ-028 Transparent texel 8'hFF -> drawingRequest=0; with ANIMATED_BITMAP_MIRROR_EN and mirrorX=1, offset (0,y) returns the texel at column 31.
REQ-029 resetN pulsed low at frame 2 mid-hold -> outputs zero immediately; the next advance occurs after a full 8 pulses.
